// File: rtl/hamming_enc_sched.sv
// Round-robin front end for the (15,11) Hamming encoder: grants one of two
// requesters, schedules single-bit error injection, and registers the codeword.
module hamming_enc_sched #(
  parameter int DATA_W = 11,
  parameter int CODE_W = 15,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              inj_en,
  input  logic [CNT_W-1:0]  inj_period,
  output logic [DATA_W-1:0] enc_data,
  output logic [3:0]        enc_err_pos,
  input  logic [CODE_W-1:0] enc_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_src,
  output logic              out_inj,
  output logic [7:0]        inj_count
);

  logic              last_reg;
  logic [CNT_W-1:0]  wcnt_reg;
  logic [3:0]        pos_reg;
  logic              out_valid_reg;
  logic [CODE_W-1:0] out_code_reg;
  logic              out_src_reg;
  logic              out_inj_reg;
  logic [7:0]        inj_count_reg;

  logic       any_valid;
  logic       winner;
  logic       can_load;
  logic       accept;
  logic       sched_on;
  logic       hit;
  logic [1:0] req_ready;

  assign any_valid = req0_valid | req1_valid;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_reg;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  assign can_load = !out_valid_reg || out_ready;
  // reset_n gating keeps the handshake quiet while reset is held low.
  assign accept   = reset_n && any_valid && can_load;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = accept && (winner == 1'(gi));
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  assign sched_on = inj_en && (inj_period != '0);
  assign hit      = sched_on && (wcnt_reg == inj_period - CNT_W'(1));

  assign enc_data    = (reset_n && any_valid) ? (winner ? req1_data : req0_data) : '0;
  assign enc_err_pos = (reset_n && any_valid && hit) ? pos_reg : 4'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_reg      <= 1'b1;
      wcnt_reg      <= '0;
      pos_reg       <= 4'd1;
      out_valid_reg <= 1'b0;
      out_code_reg  <= '0;
      out_src_reg   <= 1'b0;
      out_inj_reg   <= 1'b0;
      inj_count_reg <= 8'd0;
    end else begin
      if (accept) begin
        last_reg      <= winner;
        out_valid_reg <= 1'b1;
        out_code_reg  <= enc_code;
        out_src_reg   <= winner;
        out_inj_reg   <= (enc_err_pos != 4'd0);
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      // Disabling injection restarts the walk from bit 1 with a fresh count.
      if (!sched_on) begin
        wcnt_reg <= '0;
        pos_reg  <= 4'd1;
      end else if (accept) begin
        if (hit) begin
          wcnt_reg <= '0;
          pos_reg  <= (pos_reg == 4'd15) ? 4'd1 : pos_reg + 4'd1;
          if (inj_count_reg != 8'hFF) begin
            inj_count_reg <= inj_count_reg + 8'd1;
          end
        end else begin
          wcnt_reg <= wcnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_code  = out_code_reg;
  assign out_src   = out_src_reg;
  assign out_inj   = out_inj_reg;
  assign inj_count = inj_count_reg;

endmodule

// File: tb/tb_hamming_enc_sched.sv
// Directed bench for hamming_enc_sched; a behavioural (15,11) encoder closes the
// enc_data/enc_err_pos -> enc_code loop, expected codewords are hand-computed.
module tb_hamming_enc_sched;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [10:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        inj_en;
  logic [3:0]  inj_period;
  logic [10:0] enc_data;
  logic [3:0]  enc_err_pos;
  logic [14:0] enc_code;
  logic        out_valid, out_ready;
  logic [14:0] out_code;
  logic        out_src, out_inj;
  logic [7:0]  inj_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  hamming_enc_sched dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .inj_en(inj_en), .inj_period(inj_period),
    .enc_data(enc_data), .enc_err_pos(enc_err_pos), .enc_code(enc_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_src(out_src), .out_inj(out_inj), .inj_count(inj_count)
  );

  // Data bits fill non-power-of-two positions 1..15; parity at 1,2,4,8.
  function automatic logic [14:0] ref_enc(input logic [10:0] d, input logic [3:0] e);
    logic [15:0] c;
    logic        par;
    int          k;
    c = '0;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++) begin
        if (((p >> b) & 1) == 1 && (p & (p - 1)) != 0) par = par ^ c[p];
      end
      c[1 << b] = par;
    end
    if (e != 4'd0) c[e] = ~c[e];
    return c[15:1];
  endfunction

  assign enc_code = ref_enc(enc_data, enc_err_pos);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data  = '0;   req1_data  = '0;
    inj_en     = 1'b0; inj_period = 4'd0;
    out_ready  = 1'b1;
    reset_n    = 1'b0;
    #3;
    reset_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [10:0] data;
    logic        en;
    logic [3:0]  period;
    logic [3:0]  pos;
    logic [14:0] code;
    logic        inj;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{11'h000, 1'b0, 4'd0, 4'd0, 15'h0000, 1'b0, 8'd0};
    tbl[1] = '{11'h7FF, 1'b0, 4'd0, 4'd0, 15'h7FFF, 1'b0, 8'd0};
    tbl[2] = '{11'h555, 1'b0, 4'd0, 4'd0, 15'h552D, 1'b0, 8'd0};
    tbl[3] = '{11'h000, 1'b1, 4'd1, 4'd1, 15'h0001, 1'b1, 8'd1};
    tbl[4] = '{11'h7FF, 1'b1, 4'd1, 4'd2, 15'h7FFD, 1'b1, 8'd2};
    tbl[5] = '{11'h555, 1'b1, 4'd1, 4'd3, 15'h5529, 1'b1, 8'd3};
    tbl[6] = '{11'h555, 1'b1, 4'd0, 4'd0, 15'h552D, 1'b0, 8'd3};

    // Reset state, with a requester already asking.
    reset_n = 1'b0; out_ready = 1'b1; inj_en = 1'b0; inj_period = 4'd0;
    req0_valid = 1'b1; req0_data = 11'h123; req1_valid = 1'b1; req1_data = 11'h456;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_inj_count", 32'(inj_count), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_enc_data", 32'(enc_data), 32'd0);
    chk("rst_enc_err_pos", 32'(enc_err_pos), 32'd0);

    // Single requester, back-to-back, then injection rows.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req0_valid = 1'b1; req0_data = tbl[i].data;
      inj_en = tbl[i].en; inj_period = tbl[i].period;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req0_ready), 32'd1);
      chk($sformatf("v%0d_err_pos", i), 32'(enc_err_pos), 32'(tbl[i].pos));
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_out_code", i), 32'(out_code), 32'(tbl[i].code));
      chk($sformatf("v%0d_out_inj", i), 32'(out_inj), 32'(tbl[i].inj));
      chk($sformatf("v%0d_out_src", i), 32'(out_src), 32'd0);
      chk($sformatf("v%0d_inj_count", i), 32'(inj_count), 32'(tbl[i].cnt));
    end
    req0_valid = 1'b0;
    step();
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Contention: grants alternate starting with requester 0.
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_data = 11'h100 + 11'(i); req1_data = 11'h200 + 11'(i);
      #1;
      chk($sformatf("arb%0d_grant", i), 32'({req1_ready, req0_ready}), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("arb%0d_enc_data", i), 32'(enc_data), (i % 2 == 0) ? 32'h100 + 32'(i) : 32'h200 + 32'(i));
      step();
      chk($sformatf("arb%0d_out_src", i), 32'(out_src), 32'(i % 2));
    end

    // Injection walk with period 1: positions 1..15 then wrap to 1.
    do_reset();
    inj_en = 1'b1; inj_period = 4'd1; req0_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      req0_data = 11'(k * 37);
      #1;
      chk($sformatf("walk%0d_pos", k), 32'(enc_err_pos), 32'((k % 15) + 1));
      step();
      chk($sformatf("walk%0d_out_inj", k), 32'(out_inj), 32'd1);
    end
    chk("walk_inj_count", 32'(inj_count), 32'd32);

    // Period 3: hits on accepts 3, 6, 9 with positions 1, 2, 3.
    do_reset();
    inj_en = 1'b1; inj_period = 4'd3; req0_valid = 1'b1; req0_data = 11'h0F0;
    for (int k = 1; k <= 9; k++) begin
      #1;
      chk($sformatf("per3_acc%0d_pos", k), 32'(enc_err_pos), (k % 3 == 0) ? 32'(k / 3) : 32'd0);
      step();
    end
    chk("per3_inj_count", 32'(inj_count), 32'd3);

    // Back-pressure: one accept, then everything held.
    do_reset();
    begin
      int accepts;
      accepts = 0;
      inj_en = 1'b1; inj_period = 4'd3; out_ready = 1'b0;
      req0_valid = 1'b1; req0_data = 11'h7FF; req1_valid = 1'b1; req1_data = 11'h000;
      for (int i = 0; i < 5; i++) begin
        #1;
        if (req0_ready || req1_ready) accepts++;
        step();
        chk($sformatf("bp%0d_out_code", i), 32'(out_code), 32'h7FFF);
        chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
      end
      chk("bp_accepts", 32'(accepts), 32'd1);
      out_ready = 1'b1;
      #1;
      chk("bp_release_grant", 32'({req1_ready, req0_ready}), 32'd2);
      chk("bp_release_pos", 32'(enc_err_pos), 32'd0);
      step();
      chk("bp_swap_out_valid", 32'(out_valid), 32'd1);
      chk("bp_swap_out_src", 32'(out_src), 32'd1);
      chk("bp_swap_out_code", 32'(out_code), 32'h0000);
      #1;
      chk("bp_third_pos", 32'(enc_err_pos), 32'd1);
      step();
      chk("bp_third_out_code", 32'(out_code), 32'h7FFE);
      chk("bp_third_out_inj", 32'(out_inj), 32'd1);
    end

    // Async reset mid-cycle after 7 injected words.
    do_reset();
    inj_en = 1'b1; inj_period = 4'd1; req1_valid = 1'b1; req1_data = 11'h7FF;
    for (int k = 0; k < 7; k++) step();
    chk("pre_rst_inj_count", 32'(inj_count), 32'd7);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_out_src", 32'(out_src), 32'd1);
    req0_valid = 1'b1; req0_data = 11'h555;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_code", 32'(out_code), 32'd0);
    chk("arst_out_src", 32'(out_src), 32'd0);
    chk("arst_out_inj", 32'(out_inj), 32'd0);
    chk("arst_inj_count", 32'(inj_count), 32'd0);
    chk("arst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    #2;
    reset_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'({req1_ready, req0_ready}), 32'd1);
    chk("post_rst_pos", 32'(enc_err_pos), 32'd1);
    step();
    chk("post_rst_out_code", 32'(out_code), 32'h552C);
    chk("post_rst_inj_count", 32'(inj_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
